// File: rtl/lvds_link_pkg.sv
// Shared state type, LED bit map and training-word helper for the multi-lane LVDS echo link.
package lvds_link_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTrain,
    StWaitPeer,
    StEcho
  } link_state_e;

  localparam int unsigned LedLinkUp    = 7;
  localparam int unsigned LedAlignDone = 6;
  localparam int unsigned LedTimeout   = 5;
  localparam int unsigned LedLockW     = 4;

  localparam int unsigned PatMaxW = 64;

  // Keep only the low deser bits of the training pattern.
  function automatic logic [PatMaxW-1:0] pat_word(input logic [PatMaxW-1:0] pat,
                                                  input int unsigned deser);
    logic [PatMaxW-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < PatMaxW; i++) begin
      if (i < deser) mask[i] = 1'b1;
    end
    return pat & mask;
  endfunction

endpackage

// File: rtl/lvds_lane_aligner.sv
// Per-lane bitslip aligner: slips until the received word matches the training pattern,
// then declares lock after LOCK_WORDS consecutive matches.
module lvds_lane_aligner
  import lvds_link_pkg::*;
#(
  parameter int unsigned DESER      = 8,
  parameter int unsigned LOCK_WORDS = 16,
  parameter int unsigned SLIP_HOLD  = 4
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             clear,
  input  logic [DESER-1:0] rx_word,
  input  logic [DESER-1:0] pattern,
  input  logic             freeze,
  output logic             bitslip,
  output logic             locked
);

  localparam int unsigned CntW  = $clog2(LOCK_WORDS + 1);
  localparam int unsigned HoldW = (SLIP_HOLD < 1) ? 1 : $clog2(SLIP_HOLD + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(LOCK_WORDS);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             miss_q, miss_d;
  logic             slip_q, slip_d;
  logic             match;

  assign match   = (rx_word == pattern);
  assign locked  = (cnt_q == CntMax);
  assign bitslip = slip_q;

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    miss_d = miss_q;
    slip_d = 1'b0;
    if (clear) begin
      cnt_d  = '0;
      hold_d = '0;
      miss_d = 1'b0;
    end else if (!freeze) begin
      if (hold_q != '0) begin
        // SERDES still settling after a slip: rx is not trusted yet.
        hold_d = hold_q - HoldW'(1);
      end else if (match) begin
        miss_d = 1'b0;
        if (!locked) cnt_d = cnt_q + CntW'(1);
      end else if (locked) begin
        if (miss_q) begin
          cnt_d  = '0;
          miss_d = 1'b0;
        end else begin
          miss_d = 1'b1;
        end
      end else begin
        cnt_d  = '0;
        slip_d = 1'b1;
        hold_d = HoldW'(SLIP_HOLD);
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cnt_q  <= '0;
      hold_q <= '0;
      miss_q <= 1'b0;
      slip_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      miss_q <= miss_d;
      slip_q <= slip_d;
    end
  end

endmodule

// File: rtl/lvds_multilane_echo_link.sv
// N-lane LVDS link controller: trains lanes, handshakes align-done with the peer, then echoes rx.
// Optional LVDS_ECHO_PRBS_CHECK_EN adds a per-lane PRBS-7 checker (needs DESER >= 7) feeding err_cnt.
module lvds_multilane_echo_link
  import lvds_link_pkg::*;
#(
  parameter int unsigned        LANES      = 2,
  parameter int unsigned        DESER      = 8,
  parameter logic [PatMaxW-1:0] TRAIN_PAT  = 'hA5,
  parameter int unsigned        LOCK_WORDS = 16,
  parameter int unsigned        SLIP_HOLD  = 4,
  parameter int unsigned        TIMEOUT    = 65535
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [LANES*DESER-1:0] rx_data,
  output logic [LANES*DESER-1:0] tx_data,
  output logic [LANES-1:0]       rx_bitslip,
  output logic                   rx_align_done,
  input  logic                   peer_align_done,
  output logic                   link_up,
  output logic                   train_timeout,
  output logic [15:0]            err_cnt,
  output logic [7:0]             led
);

  localparam int unsigned TimW = $clog2(TIMEOUT + 1);
  localparam logic [DESER-1:0]       PatWord = DESER'(pat_word(TRAIN_PAT, DESER));
  localparam logic [LANES*DESER-1:0] PatAll  = {LANES{PatWord}};

  link_state_e            state_q, state_d;
  logic [TimW-1:0]        tmo_q, tmo_d;
  logic                   tmo_flag_q, tmo_flag_d;
  logic [LANES*DESER-1:0] echo_q;
  logic [15:0]            err_q, err_d;
  logic [LANES-1:0]       lane_locked;
  logic                   all_locked, in_echo, tmo_hit, align_clear;

  assign all_locked  = &lane_locked;
  assign in_echo     = (state_q == StEcho);
  assign tmo_hit     = (state_q == StTrain) && (tmo_q == TimW'(TIMEOUT - 1));
  assign align_clear = (state_q == StIdle) || tmo_hit || (in_echo && !peer_align_done);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lvds_lane_aligner #(
      .DESER     (DESER),
      .LOCK_WORDS(LOCK_WORDS),
      .SLIP_HOLD (SLIP_HOLD)
    ) u_aligner (
      .clk_clk    (clk_clk),
      .reset_reset(reset_reset),
      .clear      (align_clear),
      .rx_word    (rx_data[i*DESER +: DESER]),
      .pattern    (PatWord),
      .freeze     (in_echo),
      .bitslip    (rx_bitslip[i]),
      .locked     (lane_locked[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = '0;
    tmo_flag_d = tmo_flag_q;
    unique case (state_q)
      StIdle: state_d = StTrain;
      StTrain: begin
        if (tmo_hit) begin
          tmo_flag_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TimW'(1);
          if (all_locked) state_d = StWaitPeer;
        end
      end
      StWaitPeer: begin
        if (!all_locked)          state_d = StTrain;
        else if (peer_align_done) state_d = StEcho;
      end
      StEcho: if (!peer_align_done) state_d = StTrain;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_data = '0;
    unique case (state_q)
      StTrain, StWaitPeer: tx_data = PatAll;
      StEcho:              tx_data = echo_q;
      default:             tx_data = '0;
    endcase
  end

  assign link_up       = in_echo;
  assign rx_align_done = (state_q == StWaitPeer) || in_echo;
  assign train_timeout = tmo_flag_q;
  assign err_cnt       = err_q;

  always_comb begin
    led                   = '0;
    led[LedLinkUp]        = link_up;
    led[LedAlignDone]     = rx_align_done;
    led[LedTimeout]       = train_timeout;
    led[LedLockW-1:0]     = LedLockW'(lane_locked);
  end

`ifdef LVDS_ECHO_PRBS_CHECK_EN
  localparam int unsigned NErrW = $clog2(LANES + 1);

  logic [LANES*7-1:0] st_q, st_d;
  logic               seeded_q, seeded_d;
  logic [NErrW-1:0]   nerr;
  logic [16:0]        err_sum;
  logic [DESER-1:0]   exp_w;

  // Next DESER bits of x^7 + x^6 + 1, MSB first; s holds the 7 most recent bits, bit 0 newest.
  function automatic logic [DESER-1:0] prbs_word(input logic [6:0] s_in);
    logic [6:0]       s;
    logic [DESER-1:0] o;
    logic             nb;
    s = s_in;
    o = '0;
    for (int unsigned k = 0; k < DESER; k++) begin
      nb = s[6] ^ s[5];
      o  = {o[DESER-2:0], nb};
      s  = {s[5:0], nb};
    end
    return o;
  endfunction

  always_comb begin
    st_d     = st_q;
    seeded_d = seeded_q;
    nerr     = '0;
    exp_w    = '0;
    if (!in_echo) begin
      seeded_d = 1'b0;
    end else if (!seeded_q) begin
      seeded_d = 1'b1;
      for (int unsigned i = 0; i < LANES; i++) st_d[i*7 +: 7] = rx_data[i*DESER +: 7];
    end else begin
      // Local generator free-runs so one corrupted word costs exactly one error.
      for (int unsigned i = 0; i < LANES; i++) begin
        exp_w          = prbs_word(st_q[i*7 +: 7]);
        st_d[i*7 +: 7] = exp_w[6:0];
        if (rx_data[i*DESER +: DESER] != exp_w) nerr = nerr + NErrW'(1);
      end
    end
    err_sum = {1'b0, err_q} + 17'(nerr);
    err_d   = err_q;
    if (state_d == StTrain && state_q != StTrain) err_d = '0;
    else if (in_echo) err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      st_q     <= '0;
      seeded_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      seeded_q <= seeded_d;
    end
  end
`else
  assign err_d = '0;
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
      echo_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
      echo_q     <= rx_data;
      err_q      <= err_d;
    end
  end

endmodule
